// File: rtl/bf_uart_pkg.sv
// Shared types and constants for the BF core UART transmit path.
package bf_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int UART_DATA_BITS = 8;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;

endpackage

// File: rtl/bf_uart_tx_fifo.sv
// Synchronous byte FIFO with a combinational head-of-queue output.
// Pointers wrap naturally because DEPTH is a power of two.
module bf_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == (AW+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Storage has no reset so it can map onto plain memory resources.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bf_uart_tx.sv
// 8N1 UART transmitter fed by a byte FIFO; back-to-back frames with no idle gap.
// Optional BF_TX_CRLF_EN: a queued LF is sent as CR followed by LF.
module bf_uart_tx
  import bf_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          CLK,
  input  logic                          resetn,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(UART_DATA_BITS);

  tx_state_t        r_state, w_state_next;
  logic [TW-1:0]    r_timer, w_timer_next;
  logic [BW-1:0]    r_bit_idx, w_bit_idx_next;
  logic [7:0]       r_shift, w_shift_next;
  logic             r_tx, w_tx_next;

  logic             w_push;
  logic             w_pop;
  logic [7:0]       w_head;
  logic [7:0]       w_load_byte;
  logic             w_full;
  logic             w_empty;
  logic             w_bit_end;

  assign in_ready  = resetn && !w_full;
  assign w_push    = in_valid && in_ready;
  assign w_bit_end = (r_timer == TW'(CLKS_PER_BIT - 1));
  assign tx        = r_tx;
  assign busy      = (r_state != IDLE) || (fifo_count != '0);

  bf_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (CLK),
    .resetn (resetn),
    .push   (w_push),
    .pop    (w_pop),
    .din    (in_data),
    .dout   (w_head),
    .count  (fifo_count),
    .full   (w_full),
    .empty  (w_empty)
  );

`ifdef BF_TX_CRLF_EN
  logic r_lf_pending, w_lf_pending_next;
  logic w_head_is_lf;

  assign w_head_is_lf = (w_head == ASCII_LF);
  assign w_load_byte  = w_head_is_lf ? ASCII_CR : w_head;

  always_ff @(posedge CLK) begin
    if (!resetn) r_lf_pending <= 1'b0;
    else         r_lf_pending <= w_lf_pending_next;
  end
`else
  assign w_load_byte = w_head;
`endif

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_timer   <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_timer   <= w_timer_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_tx      <= w_tx_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_timer_next   = r_timer + 1'b1;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_tx_next      = r_tx;
    w_pop          = 1'b0;
`ifdef BF_TX_CRLF_EN
    w_lf_pending_next = r_lf_pending;
`endif
    case (r_state)
      IDLE: begin
        w_timer_next = '0;
        w_tx_next    = 1'b1;
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_shift_next = w_load_byte;
          w_tx_next    = 1'b0;
          w_state_next = START;
`ifdef BF_TX_CRLF_EN
          w_lf_pending_next = w_head_is_lf;
`endif
        end
      end
      START: begin
        if (w_bit_end) begin
          w_timer_next   = '0;
          w_bit_idx_next = '0;
          w_tx_next      = r_shift[0];
          w_shift_next   = r_shift >> 1;
          w_state_next   = DATA;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_timer_next = '0;
          if (r_bit_idx == BW'(UART_DATA_BITS - 1)) begin
            w_tx_next    = 1'b1;
            w_state_next = STOP;
          end else begin
            w_tx_next      = r_shift[0];
            w_shift_next   = r_shift >> 1;
            w_bit_idx_next = r_bit_idx + 1'b1;
          end
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_timer_next = '0;
          w_state_next = IDLE;
          w_tx_next    = 1'b1;
`ifdef BF_TX_CRLF_EN
          // The deferred LF goes out before anything else is popped.
          if (r_lf_pending) begin
            w_lf_pending_next = 1'b0;
            w_shift_next      = ASCII_LF;
            w_tx_next         = 1'b0;
            w_state_next      = START;
          end else
`endif
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_shift_next = w_load_byte;
            w_tx_next    = 1'b0;
            w_state_next = START;
`ifdef BF_TX_CRLF_EN
            w_lf_pending_next = w_head_is_lf;
`endif
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_tx_next    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_bf_uart_tx.sv
// Directed/randomised bench: a line decoder recovers frames from tx and compares
// them with a byte-level model of what should appear on the wire.
module tb_bf_uart_tx;

  localparam int C  = 4;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          tx;
  logic          busy;
  logic [CW-1:0] fifo_count;

  bf_uart_tx #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (D)
  ) dut (
    .CLK        (clk),
    .resetn     (resetn),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         starts[$];
  int         nstarts = 0;
  bit         saw_full = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Wire-level reference: what bytes a queued byte turns into on the line.
  function automatic void model_push(input logic [7:0] b);
`ifdef BF_TX_CRLF_EN
    if (b == 8'h0A) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end else
      exp_q.push_back(b);
`else
    exp_q.push_back(b);
`endif
  endfunction

  // Line decoder: samples mid-bit, records frame start cycles.
  bit         in_frame = 0;
  int         fstart = 0;
  int         rel;
  logic [7:0] shreg;
  always @(negedge clk) begin
    if (!resetn) begin
      in_frame = 0;
    end else if (in_frame) begin
      rel = cyc - fstart;
      if (rel == C / 2) check("start_bit", tx, 1'b0);
      if (rel >= C && rel < 9 * C && (rel % C) == C / 2) shreg[rel / C - 1] = tx;
      if (rel == 9 * C + C / 2) check("stop_bit", tx, 1'b1);
      if (rel == 10 * C - 1) begin
        got_q.push_back(shreg);
        in_frame = 0;
      end
    end else if (tx === 1'b0) begin
      in_frame = 1;
      fstart = cyc;
      starts.push_back(cyc);
      nstarts++;
    end
  end

  // Handshake invariant checked every cycle.
  always @(negedge clk) begin
    check("in_ready", in_ready, resetn && (fifo_count != CW'(D)));
    if (fifo_count == CW'(D)) saw_full = 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, output int kcyc);
    bit acc;
    in_data  = b;
    in_valid = 1'b1;
    kcyc = cyc;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        kcyc = cyc;
        in_valid = 1'b0;
        model_push(b);
        return;
      end
    end
    check("push_timeout", 1'b0, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(output int t);
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        t = cyc;
        return;
      end
    end
    check("idle_timeout", 1'b0, 1'b1);
    t = cyc;
  endtask

  task automatic compare_stream(input string tag);
    int n;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_byte"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
    starts.delete();
  endtask

  initial begin
    int k, k1, k2, t, n0;
    bit tx_low;
    logic [7:0] b;

    // Reset
    resetn = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_ready", in_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_count", fifo_count, 0);
    tick();
    resetn = 1'b1;
    tick();
    @(negedge clk);
    check("rel_ready", in_ready, 1'b1);
    check("rel_tx", tx, 1'b1);
    tick();

    // Single byte: latency and frame length
    push_byte(8'h48, k);
    wait_idle(t);
    check("single_start", starts.size() > 0 ? starts[0] : -1, k + 1);
    check("single_len", t - (k + 1), 10 * C);
    compare_stream("single");
    tick();

    // Back-to-back frames
    push_byte(8'h55, k);
    push_byte(8'hAA, k1);
    push_byte(8'h0F, k2);
    wait_idle(t);
    check("b2b_push_gap", k2 - k, 2);
    if (starts.size() == 3) begin
      check("b2b_start0", starts[0], k + 1);
      check("b2b_gap1", starts[1] - starts[0], 10 * C);
      check("b2b_gap2", starts[2] - starts[1], 10 * C);
      check("b2b_total", t - starts[0], 30 * C);
    end else
      check("b2b_nframes", starts.size(), 3);
    compare_stream("b2b");
    tick();

    // Fill the FIFO
    saw_full = 0;
    for (int i = 0; i < 6; i++) push_byte(8'($urandom_range(0, 255)), k);
    wait_idle(t);
    check("full_seen", saw_full, 1'b1);
    compare_stream("full");
    tick();

    // Reset during data bit 3 of the first frame
    push_byte(8'($urandom_range(0, 255)), k);
    push_byte(8'($urandom_range(0, 255)), k1);
    push_byte(8'($urandom_range(0, 255)), k2);
    for (int n = 0; n < 200 && cyc < k + 1 + 4 * C + 1; n++) tick();
    resetn = 1'b0;
    tick();
    @(negedge clk);
    check("mid_rst_tx", tx, 1'b1);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_busy", busy, 1'b0);
    n0 = nstarts;
    repeat (3) tick();
    resetn = 1'b1;
    tx_low = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) tx_low = 1;
    end
    check("post_rst_tx_idle", tx_low, 1'b0);
    check("post_rst_starts", nstarts - n0, 0);
    check("post_rst_frames", got_q.size(), 0);
    got_q.delete();
    exp_q.delete();
    starts.delete();
    tick();

    // Line feed
    push_byte(8'h0A, k);
    wait_idle(t);
`ifdef BF_TX_CRLF_EN
    check("lf_len", t - (k + 1), 20 * C);
`else
    check("lf_len", t - (k + 1), 10 * C);
`endif
    compare_stream("lf");
    tick();

    // Random bytes with random gaps
    for (int i = 0; i < 12; i++) begin
      b = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 30)) tick();
      push_byte(b, k);
    end
    wait_idle(t);
    compare_stream("rand");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
